mac_argmax_classifier: RTL and testbench
========================================

Name: mac_argmax_classifier

Overview:
- Output-layer stage directly downstream of the MAC/accumulator neuron block.
- Consumes one 22-bit signed accumulated neuron score per class over a valid/ready handshake and tracks the running maximum.
- After N_CLASSES scores it presents the winning digit index and its score through a valid/ready result handshake to the display/UART stage.

Parameters:
- N_CLASSES, 10, number of scores per frame (one per digit class).
- DW, 22, score width; matches the accumulator output, two's-complement signed.
- IDX_W, 4, index width; must satisfy 2^IDX_W >= N_CLASSES.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- abort  in  1  synchronous frame abort; discards the partial frame.
- score_valid  in  1  score present on score_in.
- score_ready  out  1  block can accept a score this cycle.
- score_in  in  DW  signed neuron score; class index is implied by arrival order.
- result_valid  out  1  digit/max_score are valid; held until accepted.
- result_ready  in  1  consumer accepts the result.
- digit  out  IDX_W  index of the maximum score.
- max_score  out  DW  signed value of the maximum score.
- busy  out  1  high while a frame is partially collected.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, digit=0, max_score=0, result_valid=0, busy=0, score_ready=1.
- A score is accepted when score_valid && score_ready on a rising edge. Nothing happens otherwise.
- State IDLE (cnt=0, score_ready=1, busy=0):
  - First accepted score loads best=score_in, best_idx=0, cnt=1.
  - Go to COLLECT, or directly to DONE if N_CLASSES==1.
- State COLLECT (score_ready=1, busy=1):
  - Each accepted score is compared as signed. If score_in > best (strictly), best=score_in and best_idx=cnt.
  - Then cnt=cnt+1.
  - When the accepted score is number N_CLASSES (cnt==N_CLASSES-1 before increment), go to DONE.
  - The latched digit/max_score use the post-compare values of that final cycle.
- Ties: strict greater-than, so the lowest index among equal maxima wins.
- State DONE (score_ready=0, busy=0, result_valid=1):
  - digit and max_score are stable while result_valid=1.
  - On result_valid && result_ready: result_valid=0, cnt=0, go to IDLE. score_ready rises the next cycle; there is no same-cycle bypass.
- Latency: the final score is accepted at edge t; result_valid=1 after edge t. The earliest next-frame score is accepted at the edge after the result is accepted.
- digit/max_score keep their last latched values in IDLE/COLLECT. They update only on the edge entering DONE.
- Working registers (best, best_idx) are internal and separate from the outputs.
- abort (synchronous, highest priority over everything except rst):
  - In any state: state=IDLE, cnt=0, result_valid=0. digit/max_score are left unchanged.
  - An abort in the same cycle as an accepted score discards that score.
  - An abort in DONE drops the pending result.
- Signed range: -2^(DW-1) .. 2^(DW-1)-1. The full-scale negative value must compare correctly, and no overflow is possible since there is no arithmetic, compare only.
- score_in is ignored when score_ready=0. A producer holding score_valid during DONE is stalled, not dropped.
- cnt is IDX_W wide and never exceeds N_CLASSES-1.
- Reset mid-frame or mid-DONE returns to the reset values immediately.

Test Plan:
- Scores 5,-3,100,7,0,2,99,-50,1,4 (valid every cycle) -> result_valid one cycle after the 10th; digit=2, max_score=100; score_ready=0 in DONE.
- All ten scores = -2097152 (min) except index 9 = -2097151 -> digit=9, max_score=-2097151. Then all ten = 12 -> digit=0 (tie, lowest index).
- Same frame as test 1 with random score_valid gaps and result_ready held low 5 cycles -> identical result; result_valid and outputs stable 5 cycles; score_valid during DONE is not accepted; next frame starts after the handshake.
- abort after 4 scores, then a full frame of 1..10 (ascending) -> digit=9, max_score=10; the aborted partial frame has no influence and busy drops the cycle after abort.
- abort asserted together with result_ready in DONE, and separately with an accepted score -> abort wins: result_valid=0, cnt=0, score discarded, previous digit/max_score retained.
- rst pulled low asynchronously (between clock edges) mid-COLLECT after 6 scores -> outputs go immediately to reset values; a following full frame produces the correct result.

Source files
------------

// File: rtl/mac_argmax_classifier.sv
// Argmax over N_CLASSES signed scores per frame; emits winning index and its score.
// Latency: result_valid rises on the edge that accepts the final score.
// Backpressure: score_ready is low while a result waits; the producer stalls until result_ready.
module mac_argmax_classifier #(
  parameter int N_CLASSES = 10,
  parameter int DW        = 22,
  parameter int IDX_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    abort,
  input  logic                    score_valid,
  output logic                    score_ready,
  input  logic signed [DW-1:0]    score_in,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [IDX_W-1:0]        digit,
  output logic signed [DW-1:0]    max_score,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0]     idx;
    logic signed [DW-1:0] score;
  } cand_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] cnt;
  cand_t            best;
  cand_t            cand;
  logic             score_acc;
  logic             last;

  assign score_ready = (state != DONE);
  assign score_acc   = score_valid && score_ready;

  // cand is the post-compare working value for the score currently on score_in
  always_comb begin
    cand         = best;
    last         = 1'b0;
    state_nxt    = state;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        cand.idx   = '0;
        cand.score = score_in;
        last       = (N_CLASSES == 1);
        if (score_acc) begin
          state_nxt = last ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        busy = 1'b1;
        if ($signed(score_in) > $signed(best.score)) begin
          cand.idx   = cnt;
          cand.score = score_in;
        end
        last = (cnt == LAST_IDX);
        if (score_acc && last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      best      <= '0;
      digit     <= '0;
      max_score <= '0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        cnt <= '0;
      end else if (score_acc) begin
        best <= cand;
        cnt  <= last ? '0 : cnt + IDX_ONE;
        // outputs move only on the edge that completes the frame
        if (last) begin
          digit     <= cand.idx;
          max_score <= cand.score;
        end
      end else if (result_valid && result_ready) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mac_argmax_classifier.sv
// Randomized and directed bench for mac_argmax_classifier against a queue-based frame model.
module tb_mac_argmax_classifier;
  localparam int N  = 10;
  localparam int DW = 22;
  localparam int IW = 4;
  typedef logic signed [DW-1:0] s_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          abort = 1'b0;
  logic          score_valid = 1'b0;
  logic          result_ready = 1'b0;
  s_t            score_in = '0;
  logic          score_ready;
  logic          result_valid;
  logic [IW-1:0] digit;
  s_t            max_score;
  logic          busy;

  int checks = 0;
  int failures = 0;

  mac_argmax_classifier #(.N_CLASSES(N), .DW(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .score_valid(score_valid), .score_ready(score_ready), .score_in(score_in),
    .result_valid(result_valid), .result_ready(result_ready),
    .digit(digit), .max_score(max_score), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: the partial frame is a queue; a full queue yields a pending argmax result
  s_t            frame_q[$];
  bit            m_pend = 1'b0;
  logic [IW-1:0] m_digit = '0;
  s_t            m_max = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q.delete();
      m_pend  = 1'b0;
      m_digit = '0;
      m_max   = '0;
    end else if (abort) begin
      frame_q.delete();
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (result_ready) m_pend = 1'b0;
    end else if (score_valid) begin
      frame_q.push_back(score_in);
      if (frame_q.size() == N) begin
        int bi;
        bi = 0;
        for (int i = 1; i < N; i++) if (frame_q[i] > frame_q[bi]) bi = i;
        m_digit = IW'(bi);
        m_max   = frame_q[bi];
        m_pend  = 1'b1;
        frame_q.delete();
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("score_ready", longint'(score_ready), longint'(!m_pend));
    chk("busy", longint'(busy), longint'(!m_pend && frame_q.size() > 0));
    chk("result_valid", longint'(result_valid), longint'(m_pend));
    chk("digit", longint'(digit), longint'(m_digit));
    chk("max_score", longint'(max_score), longint'(m_max));
  endtask

  always @(posedge clk) begin
    #1;
    cmp_all();
  end

  task automatic send(input s_t v, input int gaps);
    int n;
    bit acc;
    score_valid = 1'b0;
    repeat (gaps) @(negedge clk);
    score_valid = 1'b1;
    score_in    = v;
    n = 0;
    forever begin
      acc = score_ready;
      @(negedge clk);
      if (acc) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", longint'(n), 0);
        break;
      end
    end
    score_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold);
    int n;
    n = 0;
    while (!result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) chk("result_timeout", longint'(result_valid), 1);
    repeat (hold) @(negedge clk);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  function automatic s_t rnd_score();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return s_t'(-(1 << (DW - 1)));
    if (sel == 1) return s_t'((1 << (DW - 1)) - 1);
    return s_t'($urandom);
  endfunction

  s_t t1[N];

  initial begin
    t1 = '{s_t'(5), -s_t'(3), s_t'(100), s_t'(7), s_t'(0),
           s_t'(2), s_t'(99), -s_t'(50), s_t'(1), s_t'(4)};

    repeat (2) @(negedge clk);
    chk("rst_ready", longint'(score_ready), 1);
    chk("rst_valid", longint'(result_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_digit", longint'(digit), 0);
    rst = 1'b1;
    @(negedge clk);

    // basic frame, back-to-back
    for (int i = 0; i < N; i++) send(t1[i], 0);
    chk("t1_valid_latency", longint'(result_valid), 1);
    chk("t1_ready_done", longint'(score_ready), 0);
    chk("t1_digit", longint'(digit), 2);
    chk("t1_max", longint'(max_score), 100);
    wait_result(0);

    // full-scale negative, then all-tie
    for (int i = 0; i < N; i++) send((i == 9) ? s_t'(-2097151) : s_t'(-2097152), 0);
    wait_result(0);
    chk("t2_digit", longint'(digit), 9);
    chk("t2_max", longint'(max_score), -2097151);
    for (int i = 0; i < N; i++) send(s_t'(12), 0);
    wait_result(1);
    chk("t2_tie_digit", longint'(digit), 0);
    chk("t2_tie_max", longint'(max_score), 12);

    // gaps, stalled consumer, stalled producer during DONE
    for (int i = 0; i < N; i++) send(t1[i], int'($urandom_range(0, 3)));
    score_valid = 1'b1;
    score_in    = t1[0];
    for (int c = 0; c < 5; c++) begin
      chk("t3_hold_valid", longint'(result_valid), 1);
      chk("t3_hold_ready", longint'(score_ready), 0);
      chk("t3_hold_digit", longint'(digit), 2);
      chk("t3_hold_max", longint'(max_score), 100);
      @(negedge clk);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("t3_post_valid", longint'(result_valid), 0);
    chk("t3_post_ready", longint'(score_ready), 1);
    chk("t3_post_busy", longint'(busy), 0);
    for (int i = 0; i < N; i++) send(t1[i], (i == 0) ? 0 : int'($urandom_range(0, 2)));
    wait_result(0);
    chk("t3_digit", longint'(digit), 2);
    chk("t3_max", longint'(max_score), 100);

    // abort of a partial frame
    for (int i = 0; i < 4; i++) send(s_t'(1000 + i), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_busy_after_abort", longint'(busy), 0);
    for (int i = 0; i < N; i++) send(s_t'(i + 1), 0);
    wait_result(0);
    chk("t4_digit", longint'(digit), 9);
    chk("t4_max", longint'(max_score), 10);

    // abort wins over result handshake and over an accepted score
    for (int i = 0; i < N; i++) send(t1[i], 0);
    abort = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    result_ready = 1'b0;
    chk("t5_valid_dropped", longint'(result_valid), 0);
    chk("t5_digit_kept", longint'(digit), 2);
    chk("t5_max_kept", longint'(max_score), 100);
    abort = 1'b1;
    score_valid = 1'b1;
    score_in = s_t'(500);
    @(negedge clk);
    abort = 1'b0;
    score_valid = 1'b0;
    chk("t5_score_discarded", longint'(busy), 0);
    for (int i = 0; i < N; i++) send(s_t'(i + 1), 0);
    wait_result(0);
    chk("t5_digit", longint'(digit), 9);
    chk("t5_max", longint'(max_score), 10);

    // asynchronous reset mid-frame
    for (int i = 0; i < 6; i++) send(t1[i], 0);
    #2 rst = 1'b0;
    #1;
    chk("t6_busy", longint'(busy), 0);
    chk("t6_digit", longint'(digit), 0);
    chk("t6_max", longint'(max_score), 0);
    chk("t6_ready", longint'(score_ready), 1);
    chk("t6_valid", longint'(result_valid), 0);
    cmp_all();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) send(t1[i], 0);
    wait_result(0);
    chk("t6_digit_after", longint'(digit), 2);
    chk("t6_max_after", longint'(max_score), 100);

    // randomized frames, with occasional aborted partial frames
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = int'($urandom_range(1, N - 1));
        for (int i = 0; i < k; i++) send(rnd_score(), int'($urandom_range(0, 1)));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
      for (int i = 0; i < N; i++) send(rnd_score(), int'($urandom_range(0, 2)));
      wait_result(int'($urandom_range(0, 3)));
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
